id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Decode stage: register file, immediate generation and control decode, captured in the ID/EX register.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback to the read ports (write-first).
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        alu_src,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_op,
    output logic        illegal
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic [1:0]  wb_sel;
        logic [1:0]  alu_op;
        logic        illegal;
    } idex_t;

    logic [31:0] regs [32];
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1_val, rd2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    idex_t       idex_d, idex_q;

    // NOTE: this array is reset explicitly, which rules out a RAM macro; acceptable for a 32-entry flop file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign ra1 = instr_in[19:15];
    assign ra2 = instr_in[24:20];

`ifdef ID_WB_BYPASS_EN
    assign rd1_val = (ra1 == 5'd0) ? '0 : (wb_en && wb_rd == ra1) ? wb_data : regs[ra1];
    assign rd2_val = (ra2 == 5'd0) ? '0 : (wb_en && wb_rd == ra2) ? wb_data : regs[ra2];
`else
    assign rd1_val = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2_val = (ra2 == 5'd0) ? '0 : regs[ra2];
`endif

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    always_comb begin
        idex_d          = '0;
        idex_d.valid    = 1'b1;
        idex_d.pc       = pc_in;
        idex_d.rs1_data = rd1_val;
        idex_d.rs2_data = rd2_val;
        idex_d.rs1      = ra1;
        idex_d.rs2      = ra2;
        idex_d.rd       = instr_in[11:7];
        idex_d.funct3   = instr_in[14:12];
        idex_d.funct7b5 = instr_in[30];
        case (opcode_e'(instr_in[6:0]))
            OPC_LUI: begin
                idex_d.imm = imm_u; idex_d.reg_write = 1'b1; idex_d.alu_src = 1'b1; idex_d.alu_op = 2'b11;
            end
            OPC_AUIPC: begin
                idex_d.imm = imm_u; idex_d.reg_write = 1'b1; idex_d.alu_src = 1'b1;
            end
            OPC_JAL: begin
                idex_d.imm = imm_j; idex_d.reg_write = 1'b1; idex_d.jump = 1'b1; idex_d.wb_sel = 2'b10;
            end
            OPC_JALR: begin
                idex_d.imm = imm_i; idex_d.reg_write = 1'b1; idex_d.jump = 1'b1;
                idex_d.alu_src = 1'b1; idex_d.wb_sel = 2'b10;
            end
            OPC_BRANCH: begin
                idex_d.imm = imm_b; idex_d.branch = 1'b1; idex_d.alu_op = 2'b01;
            end
            OPC_LOAD: begin
                idex_d.imm = imm_i; idex_d.reg_write = 1'b1; idex_d.mem_read = 1'b1;
                idex_d.alu_src = 1'b1; idex_d.wb_sel = 2'b01;
            end
            OPC_STORE: begin
                idex_d.imm = imm_s; idex_d.mem_write = 1'b1; idex_d.alu_src = 1'b1;
            end
            OPC_OP_IMM: begin
                idex_d.imm = imm_i; idex_d.reg_write = 1'b1; idex_d.alu_src = 1'b1; idex_d.alu_op = 2'b10;
            end
            OPC_OP: begin
                idex_d.reg_write = 1'b1; idex_d.alu_op = 2'b10;
            end
            default: idex_d.illegal = 1'b1;
        endcase
    end

    // Reset and flush both leave an all-zero bubble; stall simply withholds the enable.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            idex_q <= '0;
        end else if (!stall) begin
            idex_q <= idex_d;
        end
    end

    assign valid_out = idex_q.valid;
    assign pc_out    = idex_q.pc;
    assign rs1_data  = idex_q.rs1_data;
    assign rs2_data  = idex_q.rs2_data;
    assign imm       = idex_q.imm;
    assign rs1       = idex_q.rs1;
    assign rs2       = idex_q.rs2;
    assign rd        = idex_q.rd;
    assign funct3    = idex_q.funct3;
    assign funct7b5  = idex_q.funct7b5;
    assign reg_write = idex_q.reg_write;
    assign mem_read  = idex_q.mem_read;
    assign mem_write = idex_q.mem_write;
    assign branch    = idex_q.branch;
    assign jump      = idex_q.jump;
    assign alu_src   = idex_q.alu_src;
    assign wb_sel    = idex_q.wb_sel;
    assign alu_op    = idex_q.alu_op;
    assign illegal   = idex_q.illegal;

endmodule
